// File: rtl/rv_ctrl_pkg.sv
// rv_ctrl_pkg: state, opcode and ALU-select encodings shared by the multi-cycle
// sequencer and the core decoder.
package rv_ctrl_pkg;
  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_WB_R,
    S_ADDR,
    S_MEM_RD,
    S_WB_MEM,
    S_MEM_WR,
    S_BRANCH,
    S_TRAP
  } state_t;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  function automatic state_t decode_next(input logic [6:0] opc);
    return opc == OP_R ? S_EXEC_R :
           (opc == OP_LOAD || opc == OP_STORE) ? S_ADDR :
           opc == OP_BRANCH ? S_BRANCH : S_TRAP;
  endfunction
endpackage

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle RV32 control FSM sharing one memory port between fetch and data.
// Optional performance counters are enabled by defining MULTICYCLE_CTRL_PERF_CNT_EN.
module multicycle_ctrl
  import rv_ctrl_pkg::*;
#(
  parameter int RESET_STATE_FETCH = 1,
  parameter int ALU_OP_W          = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  input  logic [6:0]          opcode,
  input  logic                zero,
  input  logic                mem_ack,
  output logic                mem_req,
  output logic                mem_we,
  output logic                addr_sel,
  output logic                ir_write,
  output logic                pc_write,
  output logic                pc_src,
  output logic                target_write,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                reg_write,
  output logic                mem_to_reg,
  output logic                illegal_instr,
  output logic                busy
`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
  ,
  output logic [31:0]         cycle_cnt,
  output logic [31:0]         instret_cnt
`endif
);
  state_t     state;
  logic       live;
  logic       held;
  logic       boot;
  logic       fetch_go;
  logic [1:0] op;
  // live keeps run from raising a request while reset is still asserted;
  // held keeps a started fetch alive even if run drops before the ack.
  assign fetch_go = live && (run || held || boot);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_FETCH;
      live  <= 1'b0;
      held  <= 1'b0;
      boot  <= (RESET_STATE_FETCH != 0);
    end else begin
      live <= 1'b1;
      held <= state == S_FETCH && fetch_go && !mem_ack;
      case (state)
        S_FETCH:  if (fetch_go && mem_ack) begin
          state <= S_DECODE;
          boot  <= 1'b0;
        end
        S_DECODE: state <= decode_next(opcode);
        S_EXEC_R: state <= S_WB_R;
        S_WB_R:   state <= S_FETCH;
        S_ADDR:   state <= opcode == OP_STORE ? S_MEM_WR : S_MEM_RD;
        S_MEM_RD: if (mem_ack) state <= S_WB_MEM;
        S_WB_MEM: state <= S_FETCH;
        S_MEM_WR: if (mem_ack) state <= S_FETCH;
        S_BRANCH: state <= S_FETCH;
        S_TRAP:   state <= S_TRAP;
        default:  state <= S_TRAP;
      endcase
    end
  end
  always_comb begin
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    addr_sel      = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_src        = 1'b0;
    target_write  = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_RS2;
    op            = ALU_ADD;
    reg_write     = 1'b0;
    mem_to_reg    = 1'b0;
    illegal_instr = 1'b0;
    case (state)
      S_FETCH: if (fetch_go) begin
        mem_req   = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ack;
        pc_write  = mem_ack;
      end
      S_DECODE: begin
        alu_src_b    = SRCB_IMM;
        target_write = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        op        = ALU_FUNCT;
      end
      S_WB_R:   reg_write = 1'b1;
      S_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEM_RD: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
      end
      S_WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        addr_sel = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        op        = ALU_SUB;
        pc_write  = zero;
        pc_src    = 1'b1;
      end
      S_TRAP:   illegal_instr = 1'b1;
      default:  illegal_instr = 1'b1;
    endcase
    alu_op = ALU_OP_W'(op);
    busy   = state != S_FETCH || fetch_go;
  end
`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
  logic retire;
  assign retire = state == S_WB_R || state == S_WB_MEM || state == S_BRANCH ||
                  (state == S_MEM_WR && mem_ack);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      if (busy) cycle_cnt <= cycle_cnt + 32'd1;
      if (retire) instret_cnt <= instret_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: randomized instruction stream against a per-phase reference of the
// control outputs, plus directed reset, trap and counter checks.
module tb_multicycle_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b0;
  logic       zero = 1'b0;
  logic       mem_ack = 1'b0;
  logic [6:0] opcode = 7'd0;
  logic       mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src, target_write;
  logic       alu_src_a, reg_write, mem_to_reg, illegal_instr, busy;
  logic [1:0] alu_src_b, alu_op;
`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
  logic [31:0] cycle_cnt, instret_cnt;
`endif
  int checks = 0;
  int errors = 0;
  localparam int P_IDLE = 0, P_FETCH = 1, P_DEC = 2, P_EXR = 3, P_WBR = 4, P_ADDR = 5;
  localparam int P_RD = 6, P_WBM = 7, P_WR = 8, P_BR = 9, P_TRAP = 10;
  localparam logic [6:0] I_R = 7'b0110011, I_LD = 7'b0000011;
  localparam logic [6:0] I_ST = 7'b0100011, I_BR = 7'b1100011;
  typedef struct packed {
    logic       req, we, as, irw, pcw, pcs, tw, asa;
    logic [1:0] asb, aop;
    logic       rw, m2r, ill, bsy;
  } sig_t;

  multicycle_ctrl #(.RESET_STATE_FETCH(0), .ALU_OP_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .zero(zero), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src), .target_write(target_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .illegal_instr(illegal_instr),
    .busy(busy)
`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
    , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Expected control outputs for each instruction phase, straight from the phase table.
  function automatic sig_t ev(int ph, logic a, logic z);
    sig_t s = '0;
    if (ph != P_IDLE) s.bsy = 1'b1;
    case (ph)
      P_FETCH: begin s.req = 1; s.asb = 2'b01; s.irw = a; s.pcw = a; end
      P_DEC:   begin s.asb = 2'b10; s.tw = 1; end
      P_EXR:   begin s.asa = 1; s.aop = 2'b10; end
      P_WBR:   s.rw = 1;
      P_ADDR:  begin s.asa = 1; s.asb = 2'b10; end
      P_RD:    begin s.req = 1; s.as = 1; end
      P_WBM:   begin s.rw = 1; s.m2r = 1; end
      P_WR:    begin s.req = 1; s.we = 1; s.as = 1; end
      P_BR:    begin s.asa = 1; s.aop = 2'b01; s.pcw = z; s.pcs = 1; end
      P_TRAP:  s.ill = 1;
      default: ;
    endcase
    return s;
  endfunction

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  task automatic chk(string tag, int ph);
    sig_t o, e;
    o = {mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src, target_write, alu_src_a,
         alu_src_b, alu_op, reg_write, mem_to_reg, illegal_instr, busy};
    e = ev(ph, mem_ack, zero);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic cyc(string tag, int ph, logic r, logic a, logic z);
    @(negedge clk);
    run = r;
    mem_ack = a;
    zero = z;
    #1 chk(tag, ph);
  endtask

  // One legal instruction: fw/dw are wait cycles before the fetch/data ack; the trailing
  // idle check proves the FSM is back in FETCH after exactly the expected number of cycles.
  task automatic do_instr(logic [6:0] opc, int fw, int dw, logic z);
    opcode = opc;
    for (int i = 0; i <= fw; i++) cyc("fetch", P_FETCH, i == 0 ? 1'b1 : rb(), i == fw, rb());
    cyc("decode", P_DEC, rb(), rb(), rb());
    if (opc == I_R) begin
      cyc("exec_r", P_EXR, rb(), rb(), rb());
      cyc("wb_r", P_WBR, rb(), rb(), rb());
    end else if (opc == I_LD || opc == I_ST) begin
      cyc("addr", P_ADDR, rb(), rb(), rb());
      for (int i = 0; i <= dw; i++)
        cyc(opc == I_LD ? "mem_rd" : "mem_wr", opc == I_LD ? P_RD : P_WR, rb(), i == dw, rb());
      if (opc == I_LD) cyc("wb_mem", P_WBM, rb(), rb(), rb());
    end else begin
      cyc("branch", P_BR, rb(), rb(), z);
    end
    cyc("idle_after", P_IDLE, 1'b0, rb(), rb());
  endtask

  task automatic async_reset(string tag);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk(tag, P_IDLE);
    @(negedge clk);
    #3 rst_n = 1'b1;
  endtask

  initial begin
    logic [6:0] ops [4];
    ops[0] = I_R; ops[1] = I_LD; ops[2] = I_ST; ops[3] = I_BR;
    run = 1'b1;
    mem_ack = 1'b1;
    @(negedge clk);
    #1 chk("reset", P_IDLE);
    @(negedge clk);
    #3 rst_n = 1'b1;
    cyc("idle_run0", P_IDLE, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) do_instr(I_R, 0, 0, 1'b0);
`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
    checks++;
    assert (cycle_cnt === 32'd12) else begin
      errors++;
      $error("FAIL cycle_cnt observed=%0d expected=12", cycle_cnt);
    end
    checks++;
    assert (instret_cnt === 32'd3) else begin
      errors++;
      $error("FAIL instret_cnt observed=%0d expected=3", instret_cnt);
    end
`endif
    do_instr(I_LD, 0, 2, 1'b0);
    do_instr(I_BR, 0, 0, 1'b1);
    do_instr(I_BR, 0, 0, 1'b0);
    do_instr(I_ST, 1, 1, 1'b0);
    for (int n = 0; n < 40; n++)
      do_instr(ops[$urandom_range(0, 3)], $urandom_range(0, 2), $urandom_range(0, 3), rb());
    opcode = 7'b1111111;
    cyc("fetch_bad", P_FETCH, 1'b1, 1'b1, 1'b0);
    cyc("decode_bad", P_DEC, rb(), rb(), rb());
    for (int i = 0; i < 25; i++) cyc("trap", P_TRAP, rb(), rb(), rb());
    async_reset("trap_reset_clear");
    cyc("idle_after_trap", P_IDLE, 1'b0, rb(), rb());
    opcode = I_ST;
    cyc("fetch_st", P_FETCH, 1'b1, 1'b1, 1'b0);
    cyc("decode_st", P_DEC, rb(), rb(), rb());
    cyc("addr_st", P_ADDR, rb(), rb(), rb());
    for (int i = 0; i < 3; i++) cyc("mem_wr_wait", P_WR, rb(), 1'b0, rb());
    async_reset("reset_mid_wr");
`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
    checks++;
    assert (cycle_cnt === 32'd0 && instret_cnt === 32'd0) else begin
      errors++;
      $error("FAIL counters_reset observed=%0d/%0d expected=0/0", cycle_cnt, instret_cnt);
    end
`endif
    cyc("idle_after_reset", P_IDLE, 1'b0, rb(), rb());
    cyc("idle_after_reset2", P_IDLE, 1'b0, 1'b1, rb());
    do_instr(I_LD, 2, 0, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle sequencer for the RV32 core datapath: one FSM steps each instruction through fetch, decode, execute, memory and writeback.
- Drives PC/IR write enables, ALU operand selects, alu_op, the shared instruction/data memory request handshake and register-file writeback.
- Supports the same opcode subset as the core decoder: R-type 0110011, LOAD 0000011, STORE 0100011, BRANCH 1100011.
- Sits between the instruction register and the datapath muxes; it replaces single-cycle control when one memory port is shared by fetch and data.

Parameters:
- RESET_STATE_FETCH, 1, if 1 leave reset directly into FETCH; if 0 idle in FETCH without requesting until run=1.
- ALU_OP_W, 2, width of alu_op.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- run  input  1  permits a new fetch; sampled only in FETCH before a request is issued.
- opcode  input  7  IR[6:0]; valid from DECODE onward.
- zero  input  1  ALU zero flag; sampled in BRANCH.
- mem_ack  input  1  memory completes the current request this cycle.
- mem_req  output  1  memory request; held until mem_ack.
- mem_we  output  1  write request; valid with mem_req.
- addr_sel  output  1  memory address select: 0 = PC, 1 = ALUOut.
- ir_write  output  1  latch the fetched word into IR.
- pc_write  output  1  PC update strobe.
- pc_src  output  1  next PC select: 0 = ALU result (PC+4), 1 = branch target register.
- target_write  output  1  latch the ALU result into the branch target register.
- alu_src_a  output  1  ALU operand A: 0 = PC, 1 = rs1.
- alu_src_b  output  2  ALU operand B: 00 = rs2, 01 = constant 4, 10 = imm.
- alu_op  output  ALU_OP_W  00 = add, 01 = sub/compare, 10 = funct-decoded.
- reg_write  output  1  register-file write enable.
- mem_to_reg  output  1  writeback select: 0 = ALUOut, 1 = MDR.
- illegal_instr  output  1  sticky flag for an unsupported opcode.
- busy  output  1  high in every state except idle FETCH.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State goes to FETCH.
  - All outputs are 0, including illegal_instr.
  - Any in-flight request is dropped; the memory side must tolerate an abandoned request.
- Outputs are Moore-decoded from the state, except ir_write/pc_write in FETCH and pc_write in BRANCH, which are qualified combinationally by mem_ack and zero.
- FETCH:
  - If run=1 (or RESET_STATE_FETCH=1 on the first cycle after reset): mem_req=1, addr_sel=0, alu_src_a=0, alu_src_b=01, alu_op=00.
  - In the cycle mem_ack=1: ir_write=1, pc_write=1, pc_src=0; next state DECODE.
  - run=0 with no request outstanding: stay in FETCH, busy=0.
  - A run drop after mem_req has asserted is ignored until ack.
- DECODE:
  - alu_src_a=0, alu_src_b=10, alu_op=00, target_write=1.
  - Next state: R-type -> EXEC_R; LOAD/STORE -> ADDR; BRANCH -> BRANCH; any other opcode -> TRAP.
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10; next WB_R.
- WB_R: reg_write=1, mem_to_reg=0; next FETCH.
- ADDR: alu_src_a=1, alu_src_b=10, alu_op=00; next MEM_RD for LOAD, MEM_WR for STORE.
- MEM_RD: mem_req=1, addr_sel=1, mem_we=0; wait for mem_ack, then WB_MEM.
- WB_MEM: reg_write=1, mem_to_reg=1; next FETCH.
- MEM_WR: mem_req=1, mem_we=1, addr_sel=1; wait for mem_ack, then FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01; pc_write=zero, pc_src=1; next FETCH.
- TRAP: illegal_instr=1 and all strobes 0; remains in TRAP until reset.
- Handshake rules:
  - mem_req, mem_we and addr_sel stay stable until the ack cycle.
  - Zero-wait ack (same cycle as the request) is legal.
  - mem_ack while mem_req=0 is ignored.
- Latency with zero-wait memory (state visits): R-type 4 cycles, LOAD 5, STORE 4, BRANCH 3. Each wait cycle adds 1.
- opcode is sampled only in DECODE and ADDR; the IR must not change in between (ir_write is 0 there).

Optional Feature:
- Macro MULTICYCLE_CTRL_PERF_CNT_EN.
- Defined: adds 32-bit outputs cycle_cnt (increments every cycle while busy=1) and instret_cnt (increments on entry to FETCH from WB_R, WB_MEM, MEM_WR or BRANCH). Both counters wrap modulo 2^32 and reset to 0.
- Undefined: the ports and counters are absent and there is no logic overhead.

Decomposition:
- Package rv_ctrl_pkg: state enum (FETCH, DECODE, EXEC_R, WB_R, ADDR, MEM_RD, WB_MEM, MEM_WR, BRANCH, TRAP), opcode constants, alu_op codes, alu_src_b codes.
- Shared with the existing decoder.
- Single module; no sub-module. The next-state and output decode are two always blocks in one file.

Test Plan:
- R-type 0110011 with zero-wait ack -> 4 cycles FETCH→DECODE→EXEC_R→WB_R; reg_write=1 for exactly 1 cycle; mem_to_reg=0.
- LOAD 0000011 with a 2-cycle wait on data ack -> MEM_RD lasts 3 cycles with mem_req steady and addr_sel=1; WB_MEM has mem_to_reg=1; total 7 cycles.
- BRANCH with zero=1 -> pc_write=1 and pc_src=1 in BRANCH. Repeat with zero=0 -> pc_write=0. Both take 3 cycles.
- Opcode 1111111 -> TRAP; illegal_instr=1 and stays set for more than 20 cycles; mem_req=0. Asserting rst_n=0 clears it asynchronously.
- rst_n pulled low mid MEM_WR while mem_req=1 -> outputs go to 0 in the same cycle; after release, FETCH with run=0 -> busy=0 and no request.
- With MULTICYCLE_CTRL_PERF_CNT_EN defined, run 3 R-types at zero-wait -> instret_cnt=3, cycle_cnt=12.
